// File: rtl/imem_fetch.sv
// Instruction memory with a valid/ready fetch port, a 1- or 2-stage read pipeline,
// address-fault reporting and a byte-enabled program-load write port.
module imem_fetch #(
    parameter int    DEPTH     = 256,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [1:0]  rsp_fault,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic [3:0]  ld_be
);
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      mem [DEPTH];
    logic             adv;
    logic             accept;
    logic             ld_hit;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] ld_idx;
    logic [1:0]       req_fault;
    logic [1:0]       unused_ld_lsb;

    logic             vld_p1;
    logic [1:0]       fault_p1;
    logic [31:0]      instr_p1;

    // Misalignment outranks out-of-range.
    function automatic logic [1:0] fault_code(input logic misaligned, input logic out_of_range);
        if (misaligned)
            return 2'b01;
        else if (out_of_range)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign adv           = !rsp_valid || rsp_ready;
    assign req_ready     = adv && !flush;
    assign accept        = req_valid && req_ready;
    assign rd_idx        = req_addr[IDX_W+1:2];
    assign ld_idx        = ld_addr[IDX_W+1:2];
    assign req_fault     = fault_code(req_addr[1:0] != 2'b00, |req_addr[31:IDX_W+2]);
    assign ld_hit        = ld_en && !(|ld_addr[31:IDX_W+2]);
    assign unused_ld_lsb = ld_addr[1:0];

    // Load port: non-blocking write gives read-first behaviour against a same-edge fetch.
    always_ff @(posedge clk) begin
        if (ld_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (ld_be[b])
                    mem[ld_idx][8*b +: 8] <= ld_data[8*b +: 8];
            end
        end
    end

    // ---- stage p1: memory read at accept ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            fault_p1 <= 2'b00;
            instr_p1 <= 32'h0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= accept;
            if (accept) begin
                fault_p1 <= req_fault;
                instr_p1 <= (req_fault == 2'b00) ? mem[rd_idx] : NOP;
            end
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic        vld_p2;
            logic [1:0]  fault_p2;
            logic [31:0] instr_p2;

            // ---- stage p2: pure register ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p2   <= 1'b0;
                    fault_p2 <= 2'b00;
                    instr_p2 <= 32'h0;
                end else if (flush) begin
                    vld_p2 <= 1'b0;
                end else if (adv) begin
                    vld_p2   <= vld_p1;
                    fault_p2 <= fault_p1;
                    instr_p2 <= instr_p1;
                end
            end

            assign rsp_valid = vld_p2;
            assign rsp_fault = fault_p2;
            assign rsp_instr = instr_p2;
        end else begin : g_lat1
            assign rsp_valid = vld_p1;
            assign rsp_fault = fault_p1;
            assign rsp_instr = instr_p1;
        end
    endgenerate

endmodule

// File: tb/tb_imem_fetch.sv
// Randomized bench for imem_fetch: an in-order scoreboard of in-flight fetches with
// a shadow memory predicts every response, req_ready and the fault codes.
module tb_imem_fetch;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] A0    = 32'hA000_0000;
    localparam logic [31:0] A1    = 32'hA111_1111;
    localparam logic [31:0] A2    = 32'hA222_2222;
    localparam logic [31:0] A3    = 32'hA333_3333;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ld_be;

    imem_fetch #(.DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
        .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  fault;
        logic [7:0]  age;     // edges survived since accept; visible when age == LAT
    } ent_t;

    ent_t        q[$];
    logic [31:0] mm [DEPTH];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t predict(input logic [31:0] a);
        ent_t e;
        e.age = 8'd1;
        if (a[1:0] != 2'b00) begin
            e.fault = 2'b01; e.instr = NOP;
        end else if ((a >> 2) >= 32'(DEPTH)) begin
            e.fault = 2'b10; e.instr = NOP;
        end else begin
            e.fault = 2'b00; e.instr = mm[a[9:2]];
        end
        return e;
    endfunction

    // One clock: check registered outputs, drive inputs, check req_ready, advance the model.
    task automatic step(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                        input logic le, input logic [31:0] la, input logic [31:0] ldd,
                        input logic [3:0] lb);
        logic ev, adv, acc;
        ev = (q.size() > 0) && (q[0].age == 8'(LAT));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_instr", rsp_instr, q[0].instr);
            chk("rsp_fault", 32'(rsp_fault), 32'(q[0].fault));
        end
        req_valid = rv; req_addr = ra; rsp_ready = rr; flush = fl;
        ld_en = le; ld_addr = la; ld_data = ldd; ld_be = lb;
        #1;
        adv = !ev || rr;
        chk("req_ready", 32'(req_ready), 32'(adv && !fl));
        acc = rv && adv && !fl;
        if (fl) begin
            q.delete();
        end else if (adv) begin
            if (ev) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 8'd1;
            if (acc) q.push_back(predict(ra));
        end
        if (le && ((la >> 2) < 32'(DEPTH))) begin
            for (int b = 0; b < 4; b++)
                if (lb[b]) mm[la[9:2]][8*b +: 8] = ldd[8*b +: 8];
        end
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] a, input logic rr);
        step(1'b1, a, rr, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) begin
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        end else if (sel < 8) begin
            a = $urandom();
            if (a[1:0] == 2'b00) a[0] = 1'b1;
        end else begin
            a = ($urandom() | 32'h0000_0400) & ~32'h3;
        end
        return a;
    endfunction

    initial begin
        logic [31:0] w, fa, la;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0; flush = 1'b0;
        ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0; ld_be = 4'h0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'h0);
        chk("reset_rsp_instr", rsp_instr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Program load of the whole memory.
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0: w = A0;
                1: w = A1;
                2: w = A2;
                3: w = A3;
                4: w = 32'h1122_3344;
                default: w = $urandom();
            endcase
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'(i) << 2, w, 4'hF);
        end
        // Out-of-range load must not alias onto word 0.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'hBAD0_BAD0, 4'hF);

        // Back-to-back fetches of the first four words.
        fetch(32'h0, 1'b1); fetch(32'h4, 1'b1); fetch(32'h8, 1'b1); fetch(32'hC, 1'b1);
        idle(LAT + 1);

        // Fault codes.
        fetch(32'h6, 1'b1); fetch(32'h400, 1'b1);
        idle(LAT + 1);

        // Back-pressure with a full pipe, then release.
        for (int i = 0; i < 5; i++) fetch(32'(i) << 2, 1'b0);
        for (int i = 5; i < 8; i++) fetch(32'(i) << 2, 1'b1);
        idle(LAT + 1);

        // Flush with two fetches in flight; the request during flush is dropped.
        fetch(32'h20, 1'b1); fetch(32'h24, 1'b1);
        step(1'b1, 32'h28, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        fetch(32'hC, 1'b1);
        idle(LAT + 1);

        // Same-cycle load and fetch to one word: old data first, new data next.
        step(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
        fetch(32'h10, 1'b1);
        idle(LAT + 1);
        chk("merged_word_model", mm[4], 32'h1122_BEEF);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            fa = rand_addr();
            la = ($urandom_range(0, 2) == 0) ? fa : rand_addr();
            step($urandom_range(0, 4) != 0, fa, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, la,
                 $urandom(), 4'($urandom()));
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 4; i++) fetch(32'(i) << 2, 1'b1);
        req_valid = 1'b0; ld_en = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("async_rst_rsp_fault", 32'(rsp_fault), 32'h0);
        chk("async_rst_rsp_instr", rsp_instr, 32'h0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(32'h0, 1'b1);
        idle(LAT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
